// File: rtl/tty_pkg.sv
// Shared definitions for the TTY UART transmitter: FSM state encoding,
// frame geometry and line levels.
package tty_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tty_state_e;

  localparam int   FRAME_DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_STOP  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/tty_uart_tx_if.sv
// Bus-side bundle of the TTY peripheral: write strobe/data from the decoder
// plus the serial line and side-band status going back out.
interface tty_uart_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             we_i;
  logic [31:0]      data_i;
  logic             tx_o;
  logic             busy_o;
  logic             empty_o;
  logic             full_o;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;

  // Decoder / testbench side.
  modport master (
    output we_i, data_i,
    input  tx_o, busy_o, empty_o, full_o, level_o, overflow_o
  );

  // Peripheral side.
  modport slave (
    input  we_i, data_i,
    output tx_o, busy_o, empty_o, full_o, level_o, overflow_o
  );
endinterface

// File: rtl/tty_uart_tx_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push and pop may coincide.
// Full/empty/level come straight from the registered pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Full is judged on pre-edge occupancy, so a push while full is dropped
  // even if a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == LVL_W'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // read after being written, and leaving it reset-free lets it map to RAM.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tty_uart_tx.sv
// TTY transmitter: buffers decoder writes in a FIFO and serialises each
// character as an 8N1 frame. FSM, baud counter, shift register and the
// sticky overflow flag live here; all outputs are registered.
module tty_uart_tx
  import tty_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  tty_uart_tx_if.slave bus
);
  localparam int                 BAUD_W      = $clog2(CLK_DIV);
  localparam int                 LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]         LAST_BIT    = 3'(FRAME_DATA_BITS - 1);

  tty_state_e        state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q, busy_q, ovf_q;

  logic [7:0]        fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              baud_done;
  logic              unused_data;

  assign unused_data = &{1'b0, bus.data_i[31:8]};
  assign baud_done   = (baud_q == '0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus.we_i),
    .wdata_i (bus.data_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pop on every START entry: from IDLE, or straight out of the last STOP cycle.
  always_comb begin
    // NOTE: default first so every path assigns fifo_pop and no latch is inferred.
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_IDLE) fifo_pop = 1'b1;
      if (state_q == ST_STOP && baud_done) fifo_pop = 1'b1;
    end
  end

  // Frame FSM with baud counter, shift register and registered line/status.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.we_i && fifo_full) ovf_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_START;
            shift_q <= fifo_rdata;
            baud_q  <= BAUD_RELOAD;
            tx_q    <= LINE_START;
            busy_q  <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_done) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            baud_q  <= BAUD_RELOAD;
            tx_q    <= shift_q[0];
          end else begin
            baud_q  <= baud_q - BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q == LAST_BIT) begin
              state_q <= ST_STOP;
              tx_q    <= LINE_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_done) begin
            if (!fifo_empty) begin
              state_q <= ST_START;
              shift_q <= fifo_rdata;
              baud_q  <= BAUD_RELOAD;
              tx_q    <= LINE_START;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= LINE_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_o       = tx_q;
  assign bus.busy_o     = busy_q;
  assign bus.empty_o    = fifo_empty;
  assign bus.full_o     = fifo_full;
  assign bus.level_o    = fifo_level;
  assign bus.overflow_o = ovf_q;

endmodule

// File: doc/tty_uart_tx.md
# tty_uart_tx

Downstream TTY peripheral of the MCU bus decoder. Consumes the decoder's TTY write strobe and write data, buffers characters in a small FIFO, and serialises each one as an 8N1 UART frame on a single TX pin. It is write-only; the decoder returns zero on reads in the TTY window, so status is exported as side-band signals only.

## Interface
- CLK_DIV, 16: clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8: character buffer depth; power of two, 2..256.
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- we_i  in  1  TTY write strobe from the bus decoder; one character per cycle.
- data_i  in  32  write data; only bits [7:0] are used, [31:8] are ignored.
- tx_o  out  1  UART serial output; idles high.
- busy_o  out  1  high while a frame is on the line.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO holds FIFO_DEPTH characters.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- Reset (rst_ni=0 at an edge): tx_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0, overflow_o=0. FSM returns to IDLE, FIFO pointers cleared, baud counter=0. This applies even mid-frame; the frame is truncated and the line returns high on that edge.
- Push: when we_i=1, data_i[7:0] is written if full_o=0 at that edge. full_o is evaluated on the pre-edge occupancy, so a push while full is dropped even if a pop happens on the same edge. A dropped push sets overflow_o, which stays at 1 until reset.
- Pop: occurs on the edge that enters START. Pop and push on the same edge leave level_o unchanged.
- There is no bypass path. Every character passes through the FIFO.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If empty_o=0, pop into the shift register and go to START.
  - START: tx_o=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0], LSB first. Each bit lasts CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle cycle). Otherwise go to IDLE.
- busy_o=1 in START, DATA and STOP.
- Baud counter: loads CLK_DIV-1 on every state or bit entry, decrements each cycle, and advances the state or bit when it reaches 0. Its width is $clog2(CLK_DIV).
- Bit index is 3 bits and must not wrap past 7.

## Timing
- Write sampled at edge N with the FIFO empty and FSM in IDLE: level_o=1 after N. Pop and START entry happen at N+1, so tx_o=0 from edge N+1.
- Frame length is exactly 10*CLK_DIV cycles. Back-to-back frames have zero gap.
- Status outputs are registered or derived from registered pointers only; no combinational path from we_i.
- Flag timing after edge N:
  - full_o and empty_o reflect occupancy after edge N.
  - overflow_o rises after the edge on which the push is dropped.

## Structure
- Shared package tty_pkg holds:
  - the state encoding (IDLE/START/DATA/STOP);
  - FRAME_DATA_BITS=8;
  - the idle and stop line level constants.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH) contains:
  - read/write pointers one bit wider than the address, for the full/empty distinction;
  - level, full and empty outputs;
  - simultaneous push/pop support.
- The top level holds the FSM, baud counter, shift register and overflow flag.

## Test plan
- Reset values, CLK_DIV=4: hold rst_ni=0 for 3 cycles -> tx_o=1, busy_o=0, empty_o=1, level_o=0, overflow_o=0.
- Single char, CLK_DIV=4: write 0x41 at edge 0 -> from edge 1, tx_o in 4-cycle bits reads 0,1,0,0,0,0,0,1,0,1. busy_o is high for 40 cycles, then IDLE.
- Upper bits ignored: write 0xDEADBE55 -> line carries 0x55: 0,1,0,1,0,1,0,1,0,1.
- Overflow, FIFO_DEPTH=8: write 0x30..0x39 on 10 consecutive cycles.
  - 0x30 is popped while 0x31 is pushed, and 0x39 is dropped.
  - overflow_o=1; full_o=1 after the 0x38 write.
  - Nine frames 0x30..0x38 are sent with no gaps, over 90*CLK_DIV cycles.
- Reset mid-frame: assert rst_ni=0 during DATA bit 3 of 0x00 -> tx_o=1 after that edge; FIFO empty, overflow_o cleared. No residual frame after release.
- Push on the last STOP cycle: write 0x7E on the final STOP cycle of the previous frame, with the FIFO otherwise empty -> IDLE for one cycle, then START. The gap is exactly 1 cycle.
